// File: rtl/dot_product_acc.sv
// Streaming dot-product engine: per-beat element products, a pairwise adder, a pipelined
// ternary adder tree and a saturating accumulator framed by first/last beat markers.
module dot_product_acc #(
   parameter int unsigned SIZEA       = 6,
   parameter int unsigned SIZEB       = 6,
   parameter int unsigned DOT         = 16,
   parameter int unsigned PIPELINE    = 1,
   parameter int unsigned SIGNED_MODE = 0,
   parameter int unsigned ACC_WIDTH   = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [SIZEA*DOT-1:0] din_a,
   input  logic [SIZEB*DOT-1:0] din_b,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] dout,
   output logic                 dout_ovf
);

   localparam int unsigned ProdW    = SIZEA + SIZEB;
   localparam int unsigned NumPairs = DOT / 2;
   // Wide enough for the full beat sum, including two (-2^(n-1))^2 products in one pair.
   localparam int unsigned SumW     = $clog2(DOT) + ProdW;

   function automatic int unsigned tree_stages(input int unsigned n);
      int unsigned c;
      int unsigned s;
      c = n;
      s = 0;
      while (c > 1) begin
         c = (c + 2) / 3;
         s++;
      end
      return s;
   endfunction

   function automatic int unsigned tree_n(input int unsigned n, input int unsigned lvl);
      int unsigned c;
      c = n;
      for (int unsigned i = 0; i < lvl; i++) c = (c + 2) / 3;
      return c;
   endfunction

   localparam int unsigned TreeStages = tree_stages(NumPairs);
   localparam int unsigned ProdStages = 1 + PIPELINE;
   localparam int unsigned MarkDepth  = ProdStages + 1 + TreeStages;
   localparam int unsigned LATENCY    = MarkDepth + 1;

   function automatic logic signed [ProdW-1:0] mult(input logic [SIZEA-1:0] ea,
                                                    input logic [SIZEB-1:0] eb);
      logic [ProdW-3:0] mag;
      logic [ProdW-1:0] pos;
      if (SIGNED_MODE != 0) begin
         return $signed({{SIZEB{ea[SIZEA-1]}}, ea}) * $signed({{SIZEA{eb[SIZEB-1]}}, eb});
      end
      mag = {{(SIZEB-1){1'b0}}, ea[SIZEA-2:0]} * {{(SIZEA-1){1'b0}}, eb[SIZEB-2:0]};
      pos = {2'b00, mag};
      // A zero magnitude negates to zero, so -0 operands drop out naturally.
      return (ea[SIZEA-1] ^ eb[SIZEB-1]) ? -pos : pos;
   endfunction

   function automatic logic signed [SumW-1:0] sext_prod(input logic signed [ProdW-1:0] p);
      return {{(SumW-ProdW){p[ProdW-1]}}, p};
   endfunction

   logic signed [ProdW-1:0]     prod_q [ProdStages][DOT];
   logic signed [SumW-1:0]      tree_d [TreeStages+1][NumPairs];
   logic signed [SumW-1:0]      tree_q [TreeStages+1][NumPairs];
   logic [MarkDepth-1:0]        vld_q, fst_q, lst_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                        ovf_q;

   logic signed [ACC_WIDTH:0]   beat_ext, base_ext, total;
   logic signed [ACC_WIDTH-1:0] clamped;
   logic                        ovf_now, ovf_acc, grp_first;

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DOT; i++) begin
         prod_q[0][i] <= mult(din_a[SIZEA*i +: SIZEA], din_b[SIZEB*i +: SIZEB]);
         for (int unsigned s = 1; s < ProdStages; s++) prod_q[s][i] <= prod_q[s-1][i];
      end
   end

   // Level 0 holds the pairwise sums; each further level folds groups of three.
   always_comb begin
      for (int unsigned j = 0; j < NumPairs; j++) begin
         tree_d[0][j] = sext_prod(prod_q[ProdStages-1][2*j]) +
                        sext_prod(prod_q[ProdStages-1][2*j+1]);
      end
      for (int unsigned l = 0; l < TreeStages; l++) begin
         for (int unsigned j = 0; j < NumPairs; j++) tree_d[l+1][j] = '0;
         for (int unsigned i = 0; i < NumPairs; i++) begin
            if (i < tree_n(NumPairs, l)) tree_d[l+1][i/3] = tree_d[l+1][i/3] + tree_q[l][i];
         end
      end
   end

   always_ff @(posedge clk) begin
      tree_q <= tree_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         fst_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q <= {vld_q[MarkDepth-2:0], in_valid};
         fst_q <= {fst_q[MarkDepth-2:0], in_valid & in_first};
         lst_q <= {lst_q[MarkDepth-2:0], in_valid & in_last};
      end
   end

   // Guard-bit add, then clamp to the signed ACC_WIDTH range.
   always_comb begin
      grp_first = fst_q[MarkDepth-1];
      beat_ext  = {{(ACC_WIDTH+1-SumW){tree_q[TreeStages][0][SumW-1]}}, tree_q[TreeStages][0]};
      base_ext  = grp_first ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
      total     = base_ext + beat_ext;
      ovf_now   = total[ACC_WIDTH] != total[ACC_WIDTH-1];
      if (!ovf_now) begin
         clamped = total[ACC_WIDTH-1:0];
      end else if (total[ACC_WIDTH]) begin
         clamped = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
         clamped = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
      ovf_acc = (grp_first ? 1'b0 : ovf_q) | ovf_now;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         dout_ovf  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (vld_q[MarkDepth-1]) begin
            if (lst_q[MarkDepth-1]) begin
               out_valid <= 1'b1;
               dout      <= clamped;
               dout_ovf  <= ovf_acc;
               acc_q     <= '0;
               ovf_q     <= 1'b0;
            end else begin
               acc_q <= clamped;
               ovf_q <= ovf_acc;
            end
         end
      end
   end

endmodule

// File: tb/tb_dot_product_acc.sv
// Bench for dot_product_acc: three DOT=4 instances (sign-magnitude, two's complement and a
// 16-bit saturating accumulator) share one stimulus stream; results are captured per instance.
module tb_dot_product_acc;

   localparam int unsigned DOT = 4;
   localparam int          LAT = 5;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_first = 1'b0;
   logic                in_last = 1'b0;
   logic [6*DOT-1:0]    din_a = '0;
   logic [6*DOT-1:0]    din_b = '0;

   logic                sm_valid, tc_valid, st_valid;
   logic                sm_ovf, tc_ovf, st_ovf;
   logic [23:0]         sm_dout, tc_dout;
   logic [15:0]         st_dout;

   typedef struct {
      longint v;
      bit     ovf;
      int     cyc;
   } res_t;

   res_t q_sm[$];
   res_t q_tc[$];
   res_t q_st[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   dot_product_acc #(.SIZEA(6), .SIZEB(6), .DOT(DOT), .PIPELINE(1), .SIGNED_MODE(0),
                     .ACC_WIDTH(24)) u_sm (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .din_a(din_a), .din_b(din_b), .out_valid(sm_valid), .dout(sm_dout), .dout_ovf(sm_ovf)
   );

   dot_product_acc #(.SIZEA(6), .SIZEB(6), .DOT(DOT), .PIPELINE(1), .SIGNED_MODE(1),
                     .ACC_WIDTH(24)) u_tc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .din_a(din_a), .din_b(din_b), .out_valid(tc_valid), .dout(tc_dout), .dout_ovf(tc_ovf)
   );

   dot_product_acc #(.SIZEA(6), .SIZEB(6), .DOT(DOT), .PIPELINE(1), .SIGNED_MODE(0),
                     .ACC_WIDTH(16)) u_st (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .din_a(din_a), .din_b(din_b), .out_valid(st_valid), .dout(st_dout), .dout_ovf(st_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sm_valid) q_sm.push_back('{v: longint'($signed(sm_dout)), ovf: sm_ovf, cyc: cyc});
      if (tc_valid) q_tc.push_back('{v: longint'($signed(tc_dout)), ovf: tc_ovf, cyc: cyc});
      if (st_valid) q_st.push_back('{v: longint'($signed(st_dout)), ovf: st_ovf, cyc: cyc});
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] sm(input int v);
      return (v < 0) ? {1'b1, 5'(-v)} : {1'b0, 5'(v)};
   endfunction

   function automatic logic [5:0] tc(input int v);
      return 6'(v);
   endfunction

   function automatic logic [23:0] pk(input logic [5:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic longint sm_dec(input logic [5:0] e);
      return e[5] ? -longint'(e[4:0]) : longint'(e[4:0]);
   endfunction

   function automatic longint tc_dec(input logic [5:0] e);
      return longint'($signed(e));
   endfunction

   function automatic longint dot_ref(input logic [23:0] a, b, input bit twos);
      longint s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         if (twos) s += tc_dec(a[6*i +: 6]) * tc_dec(b[6*i +: 6]);
         else      s += sm_dec(a[6*i +: 6]) * sm_dec(b[6*i +: 6]);
      end
      return s;
   endfunction

   task automatic beat(input logic [23:0] a, b, input logic f, l);
      din_a    = a;
      din_b    = b;
      in_first = f;
      in_last  = l;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_q();
      q_sm.delete();
      q_tc.delete();
      q_st.delete();
   endtask

   task automatic check_one(input string tag, input int sel, input longint ev, input longint eo);
      res_t q[$];
      case (sel)
         0:       q = q_sm;
         1:       q = q_tc;
         default: q = q_st;
      endcase
      check({tag, "_count"}, q.size(), 1);
      if (q.size() > 0) begin
         check({tag, "_dout"}, q[0].v, ev);
         check({tag, "_ovf"}, longint'(q[0].ovf), eo);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [23:0] a70, b70, a31, an31, ra, rb;
      longint      exp_sm[20];
      longint      exp_tc[20];
      int          k;

      a70  = pk(sm(1), sm(2), sm(3), sm(4));
      b70  = pk(sm(5), sm(6), sm(7), sm(8));
      a31  = pk(sm(31), sm(31), sm(31), sm(31));
      an31 = pk(sm(-31), sm(-31), sm(-31), sm(-31));

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {sm_valid, tc_valid, st_valid}, 0);
      check("rst_sm_dout", sm_dout, 0);
      check("rst_tc_dout", tc_dout, 0);
      check("rst_st_dout", st_dout, 0);
      check("rst_ovf", {sm_ovf, tc_ovf, st_ovf}, 0);
      rst = 1'b0;
      idle(1);

      // Single-beat group, latency and hold behaviour.
      clear_q();
      k = cyc;
      beat(a70, b70, 1'b1, 1'b1);
      idle(8);
      check_one("sm_basic", 0, 70, 0);
      if (q_sm.size() > 0) check("sm_latency", q_sm[0].cyc - k, LAT);
      check("sm_hold_dout", longint'($signed(sm_dout)), 70);
      check("sm_hold_valid", sm_valid, 0);

      clear_q();
      beat(pk(6'b100011, sm(2), 6'b100000, sm(4)), pk(sm(5), sm(-6), sm(7), sm(8)), 1'b1, 1'b1);
      idle(8);
      check_one("sm_mixed", 0, 5, 0);

      clear_q();
      beat(pk(6'b100000, 6'b100000, sm(1), sm(5)), pk(sm(31), sm(-31), sm(1), 6'b100000),
           1'b1, 1'b1);
      idle(8);
      check_one("sm_negzero", 0, 1, 0);

      clear_q();
      beat(pk(tc(-32), tc(-32), tc(31), tc(0)), pk(tc(-32), tc(31), tc(-32), tc(9)), 1'b1, 1'b1);
      idle(8);
      check_one("tc_single", 1, -960, 0);

      clear_q();
      beat(pk(tc(-32), tc(-32), tc(31), tc(0)), pk(tc(-32), tc(31), tc(-32), tc(9)), 1'b1, 1'b0);
      idle(2);
      beat(pk(tc(-32), tc(-32), tc(31), tc(0)), pk(tc(-32), tc(31), tc(-32), tc(9)), 1'b0, 1'b0);
      idle(2);
      beat(pk(tc(-32), tc(-32), tc(31), tc(0)), pk(tc(-32), tc(31), tc(-32), tc(9)), 1'b0, 1'b1);
      idle(8);
      check_one("tc_bubbles", 1, -2880, 0);

      // A new first abandons the open group; a group with no first starts from zero.
      clear_q();
      beat(a70, b70, 1'b1, 1'b0);
      beat(pk(6'b100011, sm(2), 6'b100000, sm(4)), pk(sm(5), sm(-6), sm(7), sm(8)), 1'b1, 1'b1);
      idle(8);
      check_one("sm_restart", 0, 5, 0);

      clear_q();
      beat(a70, b70, 1'b0, 1'b0);
      beat(a70, b70, 1'b0, 1'b1);
      idle(8);
      check_one("sm_nofirst", 0, 140, 0);

      clear_q();
      for (int i = 0; i < 9; i++) beat(a31, a31, i == 0, i == 8);
      idle(8);
      check_one("st_pos_sat", 2, 32767, 1);
      check_one("sm_wide", 0, 34596, 0);

      clear_q();
      beat(a31, a31, 1'b1, 1'b1);
      idle(8);
      check_one("st_after_sat", 2, 3844, 0);

      clear_q();
      for (int i = 0; i < 9; i++) beat(an31, a31, i == 0, i == 8);
      idle(8);
      check_one("st_neg_sat", 2, -32768, 1);

      clear_q();
      for (int i = 0; i < 9; i++) beat(a31, a31, i == 0, 1'b0);
      beat(an31, a31, 1'b0, 1'b1);
      idle(8);
      check_one("st_sticky", 2, 28923, 1);

      clear_q();
      beat(a31, a31, 1'b1, 1'b1);
      idle(8);
      check_one("st_sticky_clr", 2, 3844, 0);

      // Back-to-back single-beat groups against the reference model.
      clear_q();
      for (int i = 0; i < 20; i++) begin
         ra = 24'($urandom);
         rb = 24'($urandom);
         exp_sm[i] = dot_ref(ra, rb, 1'b0);
         exp_tc[i] = dot_ref(ra, rb, 1'b1);
         beat(ra, rb, 1'b1, 1'b1);
      end
      idle(8);
      check("b2b_sm_count", q_sm.size(), 20);
      check("b2b_tc_count", q_tc.size(), 20);
      for (int i = 0; i < 20 && i < q_sm.size(); i++) begin
         check($sformatf("b2b_sm_%0d", i), q_sm[i].v, exp_sm[i]);
         check($sformatf("b2b_sm_cyc_%0d", i), q_sm[i].cyc - q_sm[0].cyc, i);
      end
      for (int i = 0; i < 20 && i < q_tc.size(); i++) begin
         check($sformatf("b2b_tc_%0d", i), q_tc[i].v, exp_tc[i]);
      end

      // Reset in the middle of a group: one beat already accumulated, one still in flight.
      beat(a70, b70, 1'b1, 1'b1);
      idle(8);
      clear_q();
      beat(a70, b70, 1'b1, 1'b0);
      beat(a70, b70, 1'b0, 1'b0);
      beat(a70, b70, 1'b0, 1'b0);
      idle(2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_valid", sm_valid, 0);
      check("rst_mid_dout", sm_dout, 0);
      check("rst_mid_ovf", sm_ovf, 0);
      rst = 1'b0;
      beat(a70, b70, 1'b0, 1'b1);
      check("post_rst_dout_a", sm_dout, 0);
      idle(2);
      check("post_rst_dout_b", sm_dout, 0);
      check("post_rst_valid", sm_valid, 0);
      idle(6);
      check_one("post_rst", 0, 70, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
